// File: rtl/parking_pkg.sv
// Shared constants, state encoding and slot-arithmetic helpers for the parking gate controller.
package parking_pkg;

   localparam int NUM_SLOTS  = 4;
   localparam int SLOT_IDX_W = 2;

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_ENTRY_OPEN = 2'd1,
      S_EXIT_OPEN  = 2'd2,
      S_CLOSE_WAIT = 2'd3
   } state_t;

   localparam logic [2:0] NO_SLOT = 3'd0;

   function automatic logic [2:0] f_free_count(input logic [NUM_SLOTS-1:0] occ);
      logic [2:0] cnt;
      cnt = 3'd0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (!occ[i]) cnt = cnt + 3'd1;
      end
      return cnt;
   endfunction

   // Scan from the top so the lowest free index is the last one written.
   function automatic logic [2:0] f_best_place(input logic [NUM_SLOTS-1:0] occ);
      logic [2:0] place;
      place = NO_SLOT;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!occ[i]) place = 3'(i + 1);
      end
      return place;
   endfunction

endpackage

// File: rtl/parking_gate_controller_if.sv
// Sensor/timebase inputs and occupancy/door/status outputs of the parking gate controller.
interface parking_gate_controller_if;
   import parking_pkg::*;

   logic                  tick;
   logic                  entry_sensor;
   logic                  exit_sensor;
   logic [SLOT_IDX_W-1:0] exit_slot;
   logic [NUM_SLOTS-1:0]  slots_occupied;
   logic [2:0]            free_count;
   logic [2:0]            best_place;
   logic                  door_open;
   logic                  full_trigger;
   logic                  invalid_exit;
   logic                  busy;

   modport master (
      output tick, entry_sensor, exit_sensor, exit_slot,
      input  slots_occupied, free_count, best_place, door_open,
             full_trigger, invalid_exit, busy
   );

   modport slave (
      input  tick, entry_sensor, exit_sensor, exit_slot,
      output slots_occupied, free_count, best_place, door_open,
             full_trigger, invalid_exit, busy
   );

endinterface

// File: rtl/parking_gate_controller_sensor_sync_edge.sv
// Multi-stage synchronizer for an asynchronous sensor level plus a rising-edge pulse on the synced level.
module sensor_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_level,
   output logic o_edge
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   generate
      for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            always_ff @(posedge clk or posedge reset) begin
               if (reset) r_sync[gi] <= 1'b0;
               else       r_sync[gi] <= i_async;
            end
         end else begin : g_next
            always_ff @(posedge clk or posedge reset) begin
               if (reset) r_sync[gi] <= 1'b0;
               else       r_sync[gi] <= r_sync[gi-1];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_prev <= 1'b0;
      else       r_prev <= o_level;
   end

   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_edge  = o_level & ~r_prev;

endmodule

// File: rtl/parking_gate_controller.sv
// Arbitrated entry/exit sequencer: owns slot occupancy, allocates the lowest free slot and times the door.
module parking_gate_controller
   import parking_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DOOR_HOLD_TICKS = 200
) (
   input logic                    clk,
   input logic                    reset,
   parking_gate_controller_if.slave bus
);

   localparam int HOLD_W = $clog2(DOOR_HOLD_TICKS + 1);

   logic w_entry_level, w_entry_edge;
   logic w_exit_level,  w_exit_edge;

   sensor_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_entry_sync (
      .clk     (clk),
      .reset   (reset),
      .i_async (bus.entry_sensor),
      .o_level (w_entry_level),
      .o_edge  (w_entry_edge)
   );

   sensor_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_exit_sync (
      .clk     (clk),
      .reset   (reset),
      .i_async (bus.exit_sensor),
      .o_level (w_exit_level),
      .o_edge  (w_exit_edge)
   );

   state_t                r_state;
   logic [NUM_SLOTS-1:0]  r_slots;
   logic                  r_door;
   logic                  r_busy;
   logic                  r_full;
   logic                  r_invalid;
   logic                  r_pend_entry;
   logic                  r_pend_exit;
   logic [SLOT_IDX_W-1:0] r_pend_slot;
   logic [HOLD_W-1:0]     r_hold;

   logic [NUM_SLOTS-1:0]  w_lowest_free_mask;
   logic [2:0]            w_free_count;

   // Isolates the lowest zero bit of the occupancy word.
   assign w_lowest_free_mask = ~r_slots & (r_slots + 4'd1);
   assign w_free_count       = f_free_count(r_slots);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_slots      <= '0;
         r_door       <= 1'b0;
         r_busy       <= 1'b0;
         r_full       <= 1'b0;
         r_invalid    <= 1'b0;
         r_pend_entry <= 1'b0;
         r_pend_exit  <= 1'b0;
         r_pend_slot  <= '0;
         r_hold       <= '0;
      end else begin
         r_full    <= 1'b0;
         r_invalid <= 1'b0;

         // One-deep latches: an edge arriving while the latch is already set is dropped.
         if (w_entry_edge && !r_pend_entry) r_pend_entry <= 1'b1;
         if (w_exit_edge && !r_pend_exit) begin
            r_pend_exit <= 1'b1;
            r_pend_slot <= bus.exit_slot;
         end

         case (r_state)
            S_IDLE: begin
               if (r_pend_exit) begin
                  r_pend_exit <= 1'b0;
                  if (r_slots[r_pend_slot]) begin
                     r_slots[r_pend_slot] <= 1'b0;
                     r_state <= S_EXIT_OPEN;
                     r_door  <= 1'b1;
                     r_busy  <= 1'b1;
                     r_hold  <= '0;
                  end else begin
                     r_invalid <= 1'b1;
                  end
               end else if (r_pend_entry) begin
                  r_pend_entry <= 1'b0;
                  if (w_free_count != 3'd0) begin
                     r_slots <= r_slots | w_lowest_free_mask;
                     r_state <= S_ENTRY_OPEN;
                     r_door  <= 1'b1;
                     r_busy  <= 1'b1;
                     r_hold  <= '0;
                  end else begin
                     r_full <= 1'b1;
                  end
               end
            end
            S_ENTRY_OPEN, S_EXIT_OPEN: begin
               if (bus.tick) begin
                  if (r_hold == HOLD_W'(DOOR_HOLD_TICKS - 1)) r_state <= S_CLOSE_WAIT;
                  else                                        r_hold  <= r_hold + 1'b1;
               end
            end
            S_CLOSE_WAIT: begin
               if (!w_entry_level && !w_exit_level) begin
                  r_state <= S_IDLE;
                  r_door  <= 1'b0;
                  r_busy  <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.slots_occupied = r_slots;
   assign bus.free_count     = w_free_count;
   assign bus.best_place     = f_best_place(r_slots);
   assign bus.door_open      = r_door;
   assign bus.full_trigger   = r_full;
   assign bus.invalid_exit   = r_invalid;
   assign bus.busy           = r_busy;

endmodule

// File: doc/parking_gate_controller.md
Name: parking_gate_controller

Overview:
- Sequencing controller for the 4-slot parking datapath: owns the slot-occupancy register, arbitrates entry vs exit requests, allocates the best (lowest-index) free slot and times the door.
- Sits between raw sensors/switches and the display/flasher blocks: door_open feeds the door flasher, full_trigger feeds the full flasher, and free_count/best_place feed the seven-segment path.
- Replaces the direct state-to-LED wiring with a single arbitrated state machine.

Parameters:
- NUM_SLOTS, 4, number of parking slots; occupancy width; fixed at 4 for this revision.
- SYNC_STAGES, 2, flip-flop stages on each asynchronous sensor input.
- DOOR_HOLD_TICKS, 200, tick pulses for which the door stays open (2 s at 100 Hz).

Ports:
- clk  in  1  system clock (40 MHz).
- reset  in  1  asynchronous, active-high; clears all state.
- tick  in  1  one-clk-wide timebase enable (the 100 Hz divider output, pulsed).
- entry_sensor  in  1  asynchronous car-at-entry level.
- exit_sensor  in  1  asynchronous car-at-exit level.
- exit_slot  in  2  slot index being vacated, sampled with the exit edge.
- slots_occupied  out  4  occupancy; bit i = slot i taken.
- free_count  out  3  number of zero bits in slots_occupied (0..4).
- best_place  out  3  lowest free slot index + 1; 0 when full.
- door_open  out  1  level; high while the door is open.
- full_trigger  out  1  one-cycle pulse; entry refused because the lot is full.
- invalid_exit  out  1  one-cycle pulse; exit requested for an empty slot.
- busy  out  1  high when the FSM is not IDLE.

Behaviour:
- Reset (async): slots_occupied=0, free_count=4, best_place=1, door_open=0, pulses=0, busy=0, FSM=IDLE, pending flags=0, hold counter=0.
- Inputs: entry_sensor and exit_sensor each pass through SYNC_STAGES flops. A request is a rising edge of the synchronized signal, detected 1 clk after sync. exit_slot is captured in the same cycle as the exit edge.
- Pending latches:
  - pend_entry and pend_exit are each 1 deep. Each is set by its edge in any state.
  - A second edge while a latch is already set is dropped.
  - pend_exit also stores its slot index.
- FSM states: IDLE, ENTRY_OPEN, EXIT_OPEN, CLOSE_WAIT.
- IDLE arbitration, evaluated each cycle. Exit has priority over entry.
  - pend_exit and slot occupied: clear that bit at the next edge, clear pend_exit, go to EXIT_OPEN.
  - pend_exit and slot empty: invalid_exit pulses 1 cycle, clear pend_exit, stay IDLE.
  - Else pend_entry and free_count>0: set the bit of the lowest free slot at the next edge, clear pend_entry, go to ENTRY_OPEN.
  - Else pend_entry and full: full_trigger pulses 1 cycle, clear pend_entry, stay IDLE.
  - If an exit and an entry are both pending, the exit is served first. The entry is evaluated in IDLE after CLOSE_WAIT, so a full lot accepts it once space is freed.
- ENTRY_OPEN / EXIT_OPEN:
  - door_open=1. The hold counter is cleared on entry to the state and increments on each tick.
  - At count == DOOR_HOLD_TICKS-1 with tick high, go to CLOSE_WAIT.
- CLOSE_WAIT:
  - door_open stays 1 until both synchronized sensors are low, then go to IDLE with door_open=0 from the next cycle.
  - Requests that arrive during this state are only latched.
- Outputs are registered:
  - slots_occupied, door_open and busy update on the same edge as the state change.
  - free_count and best_place are combinational from the registered occupancy, so they are valid in the same cycle as slots_occupied.
- Arithmetic:
  - free_count is a 3-bit popcount of ~slots_occupied.
  - best_place comes from a priority encoder, with slot 0 highest priority.
- Reset asserted mid-door: the door closes immediately, occupancy clears and pending requests are lost. No pulse is emitted.
- A tick coincident with the state-entry edge is not counted. The hold duration is exactly DOOR_HOLD_TICKS ticks after entry.

Decomposition:
- Shared package parking_pkg:
  - NUM_SLOTS and SLOT_IDX_W=2.
  - State encoding constants S_IDLE=0, S_ENTRY_OPEN=1, S_EXIT_OPEN=2, S_CLOSE_WAIT=3.
  - NO_SLOT=3'd0.
- One sub-module: sensor_sync_edge, a SYNC_STAGES synchronizer plus rising-edge detector. It is instantiated twice and exposes a synchronized level and an edge pulse.
- Slot allocation (priority encoder and popcount) stays inline.

Test Plan:
- Reset, then one entry edge -> after sync+1 clk slots_occupied=0001, best_place=2, free_count=3, door_open=1 for 200 ticks; after the sensor drops, busy=0.
- Four sequential entries -> occupancy 1111, best_place=0, free_count=0; a fifth entry -> full_trigger one pulse, door_open stays 0, occupancy unchanged.
- Lot full, entry and exit (exit_slot=2) edges in the same cycle -> exit served first (occupancy 1011, door cycle), then the entry is granted slot 2 -> 1111 with a second door cycle.
- Occupancy 0001, exit with exit_slot=3 -> invalid_exit pulse, no door, occupancy 0001.
- Entry edge during ENTRY_OPEN, plus a third edge -> exactly one extra grant after CLOSE_WAIT; the extra edge is dropped.
- Reset asserted at tick 100 of the door hold -> door_open=0, occupancy=0 and busy=0 immediately (async), with no pulses emitted.
